uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_WIDTH bits LSB first, optional parity (`UART_TX_PARITY_EN), stop bit.
// TX_OUT/Busy are registered and lag acceptance by one edge; DATA_VALID is only honoured in IDLE (no queueing).
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;

`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_typ;
`else
    logic                  w_unused_par;
    assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (DATA_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = DATA;
            DATA: begin
                if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    w_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = r_par_en ? PARITY : STOP;
`else
                    w_state_nxt = STOP;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: w_state_nxt = STOP;
`endif
            STOP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line value is computed for the state being entered so the output flop matches the state flop.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        case (w_state_nxt)
            IDLE:   w_busy_nxt = 1'b0;
            START:  w_tx_nxt   = 1'b0;
            DATA:   w_tx_nxt   = r_data[w_cnt_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY: w_tx_nxt   = (^r_data) ^ r_par_typ;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            if (w_accept) begin
                r_data <= P_DATA;
`ifdef UART_TX_PARITY_EN
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
`endif
            end
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
